// File: rtl/serial_borrow_skip_subtractor_pkg.sv
// serial_borrow_skip_subtractor_pkg: shared block width and FSM state encoding.
package serial_borrow_skip_subtractor_pkg;
    localparam int BLOCK_W = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_borrow_skip_subtractor_block4.sv
// block4_borrow_skip_sub: 4-bit ripple subtract slice with a borrow-skip bypass.
module block4_borrow_skip_sub
    import serial_borrow_skip_subtractor_pkg::*;
(
    input  logic [BLOCK_W-1:0] a4,
    input  logic [BLOCK_W-1:0] b4,
    input  logic               borrow_in,
    output logic [BLOCK_W-1:0] d4,
    output logic               borrow_out,
    output logic               skipped
);
    logic [BLOCK_W:0]   br;
    logic [BLOCK_W-1:0] p;
    assign p = ~(a4 ^ b4);
    always_comb begin
        br[0] = borrow_in;
        for (int i = 0; i < BLOCK_W; i++) begin
            d4[i]    = a4[i] ^ b4[i] ^ br[i];
            br[i+1]  = (~a4[i] & b4[i]) | (p[i] & br[i]);
        end
    end
    // With a4 == b4 the slice computes -borrow_in, so forwarding borrow_in is exact.
    assign skipped    = &p;
    assign borrow_out = skipped ? borrow_in : br[BLOCK_W];
endmodule

// File: rtl/serial_borrow_skip_subtractor.sv
// serial_borrow_skip_subtractor: multi-cycle a - b - bin, one 4-bit borrow-skip block per clock.
module serial_borrow_skip_subtractor
    import serial_borrow_skip_subtractor_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int NB    = WIDTH / BLOCK_W,
    localparam int CNT_W = $clog2(NB + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf,
    output logic [CNT_W-1:0] skip_cnt
);
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    state_t                         state_q, state_d;
    logic [NB-1:0][BLOCK_W-1:0]     a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           borrow_q, borrow_d;
    logic                           bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d;
    logic [CNT_W-1:0]               skip_q, skip_d;
    logic [BLOCK_W-1:0]             blk_d;
    logic                           blk_bout, blk_skip, last;

    block4_borrow_skip_sub u_blk (
        .a4         (a_q[idx_q]),
        .b4         (b_q[idx_q]),
        .borrow_in  (borrow_q),
        .d4         (blk_d),
        .borrow_out (blk_bout),
        .skipped    (blk_skip)
    );

    assign last = (idx_q == IDX_W'(NB - 1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        skip_d   = skip_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d      = a;
                b_d      = b;
                borrow_d = bin;
                skip_d   = '0;
                idx_d    = '0;
                state_d  = RUN;
            end
            RUN: begin
                diff_d[idx_q] = blk_d;
                borrow_d      = blk_bout;
                skip_d        = skip_q + CNT_W'(blk_skip);
                idx_d         = idx_q + 1'b1;
                // Flags are taken from the result including the block written this edge.
                if (last) begin
                    idx_d   = '0;
                    state_d = DONE;
                    bout_d  = blk_bout;
                    zero_d  = (diff_d == '0);
                    ovf_d   = (a_q[NB-1][BLOCK_W-1] != b_q[NB-1][BLOCK_W-1]) &&
                              (diff_d[NB-1][BLOCK_W-1] != a_q[NB-1][BLOCK_W-1]);
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            skip_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            skip_q   <= skip_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign skip_cnt  = skip_q;
endmodule

// File: tb/tb_serial_borrow_skip_subtractor.sv
// tb_serial_borrow_skip_subtractor: scoreboard bench with directed cases, backpressure, reset and random sweep.
module tb_serial_borrow_skip_subtractor;
    localparam int W  = 16;
    localparam int NB = W / 4;
    localparam int CW = $clog2(NB + 1);

    logic          clk = 0, rst_n = 0, in_valid = 0, bin = 0, out_ready = 1;
    logic [W-1:0]  a = '0, b = '0;
    logic          in_ready, out_valid, bout, zero, ovf;
    logic [W-1:0]  diff;
    logic [CW-1:0] skip_cnt;
    bit            bp_hold = 0, rand_rdy = 0;

    typedef struct packed {
        logic [W-1:0]  d;
        logic          bo;
        logic          z;
        logic          o;
        logic [CW-1:0] s;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   n_vec = 0, n_err = 0;

    serial_borrow_skip_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .zero(zero), .ovf(ovf), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = bp_hold ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        exp_t e;
        int   sa, sb, sd;
        int unsigned ua, ub, raw;
        ua   = av;
        ub   = bv;
        raw  = ua - ub - bi;
        e.d  = raw[W-1:0];
        e.bo = (ua < ub + bi);
        e.z  = (e.d == '0);
        sa   = av[W-1] ? int'(ua) - (1 << W) : int'(ua);
        sb   = bv[W-1] ? int'(ub) - (1 << W) : int'(ub);
        sd   = sa - sb - int'(bi);
        e.o  = (sd < -(1 << (W - 1))) || (sd >= (1 << (W - 1)));
        e.s  = '0;
        for (int i = 0; i < NB; i++)
            if (((ua >> (4 * i)) & 15) == ((ub >> (4 * i)) & 15)) e.s = e.s + 1'b1;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got diff %h with empty scoreboard", diff);
            end else begin
                e_mon = q.pop_front();
                chk("diff", diff, e_mon.d);
                chk("bout", W'(bout), W'(e_mon.bo));
                chk("zero", W'(zero), W'(e_mon.z));
                chk("ovf", W'(ovf), W'(e_mon.o));
                chk("skip_cnt", W'(skip_cnt), W'(e_mon.s));
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
        if (!in_ready) begin n_err++; $display("FAIL accept_timeout: in_ready 0 expected 1"); end
    endtask

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi, input exp_t e);
        int t = 0;
        wait_ready();
        in_valid = 1; a = av; b = bv; bin = bi;
        q.push_back(e);
        n_vec++;
        @(posedge clk); #1;
        in_valid = 0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
        chk("latency", W'(t), W'(NB));
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin @(posedge clk); #1; t++; end
        if (q.size() != 0) begin n_err++; $display("FAIL drain_timeout: %0d pending expected 0", q.size()); end
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_diff", diff, '0);
        chk("rst_bout", W'(bout), W'(0));
        chk("rst_zero", W'(zero), W'(0));
        chk("rst_ovf", W'(ovf), W'(0));
        chk("rst_skip", W'(skip_cnt), W'(0));
    endtask

    logic [W-1:0]  da[5] = '{16'h1234, 16'h0000, 16'h8000, 16'hABCD, 16'hABCD};
    logic [W-1:0]  db[5] = '{16'h0234, 16'h0001, 16'h0001, 16'hABCD, 16'hABCD};
    logic          dbi[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_t          dex[5] = '{
        '{16'h1000, 1'b0, 1'b0, 1'b0, 3'd3},
        '{16'hFFFF, 1'b1, 1'b0, 1'b0, 3'd3},
        '{16'h7FFF, 1'b0, 1'b0, 1'b1, 3'd2},
        '{16'h0000, 1'b0, 1'b1, 1'b0, 3'd4},
        '{16'hFFFF, 1'b1, 1'b0, 1'b0, 3'd4}};

    initial begin
        exp_t         e;
        logic [W-1:0] ra, rb, m;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals();
        rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) send(da[i], db[i], dbi[i], dex[i]);
        drain();

        // Backpressure: result must hold and extra operands must be ignored.
        bp_hold = 1;
        @(posedge clk); #1;
        e = model(16'h4321, 16'h1234, 1'b0);
        send(16'h4321, 16'h1234, 1'b0, e);
        in_valid = 1; a = 16'hFFFF; b = 16'h0001; bin = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", W'(out_valid), W'(1));
            chk("bp_in_ready", W'(in_ready), W'(0));
            chk("bp_diff", diff, e.d);
            chk("bp_skip", W'(skip_cnt), W'(e.s));
        end
        in_valid = 0;
        bp_hold  = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", W'(in_ready), W'(1));
        chk("bp_release_out_valid", W'(out_valid), W'(0));
        send(16'h00F0, 16'h000F, 1'b1, model(16'h00F0, 16'h000F, 1'b1));
        drain();

        // Reset in the middle of RUN discards the partial result.
        wait_ready();
        in_valid = 1; a = 16'h9999; b = 16'h1111; bin = 0;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk_reset_vals();
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        send(16'h0005, 16'h0003, 1'b0, '{16'h0002, 1'b0, 1'b0, 1'b0, 3'd3});
        drain();

        rand_rdy = 1;
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            m  = '0;
            for (int k = 0; k < NB; k++) if ($urandom_range(0, 1) != 0) m[4*k +: 4] = 4'hF;
            rb = (ra & m) | (rb & ~m);
            bin = 1'($urandom);
            send(ra, rb, bin, model(ra, rb, bin));
        end
        drain();
        rand_rdy = 0;
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
